// File: rtl/dcache_mem_stage_if.sv
// Bus bundle between the MEM-stage data cache, the pipeline registers and the shared memory.
// The slave view is the cache; the master view is the pipeline plus memory around it.
interface dcache_mem_stage_if #(
  parameter int LINE_WORDS = 4
);
  logic                     cpu_read;
  logic                     cpu_write;
  logic [15:0]              cpu_addr;
  logic [15:0]              cpu_wdata;
  logic [15:0]              cpu_rdata;
  logic                     stall_mem;
  logic                     mem_read;
  logic                     mem_write;
  logic [15:0]              mem_addr;
  logic [15:0]              mem_wdata;
  logic [16*LINE_WORDS-1:0] mem_rdata;
  logic                     mem_ready;
  logic [15:0]              hit_count;
  logic [15:0]              miss_count;

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    output cpu_rdata, stall_mem, mem_read, mem_write, mem_addr, mem_wdata,
           hit_count, miss_count
  );

  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    input  cpu_rdata, stall_mem, mem_read, mem_write, mem_addr, mem_wdata,
           hit_count, miss_count
  );
endinterface

// File: rtl/dcache_mem_stage.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Read hits complete combinationally; misses fill a whole line from the shared memory.
module dcache_mem_stage #(
  parameter int LINES      = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic               clk,
  input  logic               reset,
  dcache_mem_stage_if.slave  bus
);
  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int TAG_W = 16 - IDX_W - OFF_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [15:0]        data_q [LINES][LINE_WORDS];

  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [15:0]        mem_addr_q, mem_addr_d;
  logic [15:0]        mem_wdata_q, mem_wdata_d;
  logic [15:0]        hit_count_q, hit_count_d;
  logic [15:0]        miss_count_q, miss_count_d;

  logic [OFF_W-1:0]   off;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               fill_en;
  logic               wr_en;
  logic               stall;

  assign off = bus.cpu_addr[OFF_W-1:0];
  assign idx = bus.cpu_addr[OFF_W +: IDX_W];
  assign tag = bus.cpu_addr[15 -: TAG_W];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    fill_en      = 1'b0;
    wr_en        = 1'b0;
    stall        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A store wins over a simultaneous load.
        if (bus.cpu_write) begin
          stall = 1'b1;
          if (hit) hit_count_d  = hit_count_q + 16'd1;
          else     miss_count_d = miss_count_q + 16'd1;
          mem_write_d = 1'b1;
          mem_addr_d  = bus.cpu_addr;
          mem_wdata_d = bus.cpu_wdata;
          state_d     = WRITE;
        end else if (bus.cpu_read) begin
          if (hit) begin
            hit_count_d = hit_count_q + 16'd1;
          end else begin
            stall        = 1'b1;
            miss_count_d = miss_count_q + 16'd1;
            mem_read_d   = 1'b1;
            mem_addr_d   = {bus.cpu_addr[15:OFF_W], {OFF_W{1'b0}}};
            state_d      = FILL;
          end
        end
      end
      FILL: begin
        stall = 1'b1;
        if (bus.mem_ready) begin
          mem_read_d   = 1'b0;
          fill_en      = 1'b1;
          valid_d[idx] = 1'b1;
          state_d      = DONE;
        end
      end
      WRITE: begin
        stall = 1'b1;
        if (bus.mem_ready) begin
          mem_write_d = 1'b0;
          wr_en       = hit;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone make them meaningful.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx] <= tag;
      for (int w = 0; w < LINE_WORDS; w++) begin
        data_q[idx][w] <= bus.mem_rdata[16*w +: 16];
      end
    end else if (wr_en) begin
      data_q[idx][off] <= bus.cpu_wdata;
    end
  end

  assign bus.cpu_rdata  = data_q[idx][off];
  assign bus.stall_mem  = stall;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.hit_count  = hit_count_q;
  assign bus.miss_count = miss_count_q;
endmodule
